// File: rtl/hs_pkg.sv
// Shared types and default widths for the req/ack handshake responder.
package hs_pkg;

    // Default width of the latency input; maximum latency is 2**HS_LAT_W-1.
    localparam int unsigned HS_LAT_W = 4;

    // Default width of the completed-transaction counter.
    localparam int unsigned HS_CNT_W = 8;

    // Responder phases: idle, counting down the latency, holding ack.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/hs_sat_cnt.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
module hs_sat_cnt
    import hs_pkg::*;
#(
    parameter int unsigned W = HS_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: advance on inc unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hs_responder.sv
// Responder end of a four-phase req/ack handshake with programmable latency,
// protocol-violation flag and saturating completed-transaction count.
module hs_responder
    import hs_pkg::*;
#(
    parameter int unsigned LAT_W = HS_LAT_W,
    parameter int unsigned CNT_W = HS_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [LAT_W-1:0] lat,
    input  logic             enable,
    output logic             ack,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] txn_cnt
);

    state_t           state_q;
    state_t           state_d;
    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;
    logic             ack_q;
    logic             ack_d;
    logic             busy_q;
    logic             busy_d;
    logic             err_q;
    logic             err_d;
    logic             done;

    // Next-state, latency countdown, violation detect and completion pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // enable only gates acceptance of a new request.
                if (req && enable) begin
                    if (lat == '0) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = lat - LAT_W'(1);
                    end
                end
            end
            WAIT: begin
                // Withdrawn req wins over a counter that expires this cycle.
                if (!req) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            ACK: begin
                // Holding ack while req stays high is legal; only a drop completes.
                if (!req) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered decodes of the next state, so they have
        // no combinational path from req.
        ack_d  = (state_d == ACK);
        busy_d = (state_d != IDLE);
    end

    // State, countdown and registered outputs with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    hs_sat_cnt #(
        .W (CNT_W)
    ) u_txn_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (done),
        .count (txn_cnt)
    );

    assign ack  = ack_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_hs_responder.sv
// Self-checking bench for hs_responder: directed scenarios plus a randomized
// run checked against a deadline-based transaction model.
module tb_hs_responder;
    import hs_pkg::*;

    localparam int unsigned TB_LAT_W = HS_LAT_W;
    localparam int unsigned TB_CNT_W = 2;
    localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                req;
    logic [TB_LAT_W-1:0] lat;
    logic                enable;
    logic                ack;
    logic                busy;
    logic                err;
    logic [TB_CNT_W-1:0] txn_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: a transaction is either absent, waiting for its
    // deadline edge (accept edge + lat), or acknowledged.
    bit m_busy;
    bit m_ack;
    bit m_err;
    int m_cnt;
    int m_due;
    int edge_no = 0;

    hs_responder #(
        .LAT_W (TB_LAT_W),
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lat     (lat),
        .enable  (enable),
        .ack     (ack),
        .busy    (busy),
        .err     (err),
        .txn_cnt (txn_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_busy = 1'b0;
        m_ack  = 1'b0;
        m_err  = 1'b0;
        m_cnt  = 0;
        m_due  = 0;
    endtask

    // One clock: inputs already driven; model consumes the sampled inputs at
    // the rising edge; returns at the falling edge for checking/driving.
    task automatic tick();
        @(posedge clk);
        edge_no++;
        if (rst) begin
            model_reset();
        end else begin
            m_err = 1'b0;
            if (!m_busy) begin
                if (req && enable) begin
                    m_busy = 1'b1;
                    m_due  = edge_no + int'(lat);
                    m_ack  = (lat == 0);
                end
            end else if (!m_ack) begin
                if (!req) begin
                    m_err  = 1'b1;
                    m_busy = 1'b0;
                end else if (edge_no >= m_due) begin
                    m_ack = 1'b1;
                end
            end else if (!req) begin
                m_ack  = 1'b0;
                m_busy = 1'b0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        req    = 1'b0;
        enable = 1'b1;
        lat    = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        req    = 1'b1;
        lat    = 4'd3;
        enable = 1'b1;
        repeat (3) tick();
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (txn_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", txn_cnt); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_release_busy got=%b exp=1", busy); end
        tick();
        tick();
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_release_early_ack got=%b exp=0", ack); end
        tick();
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL reset_release_ack got=%b exp=1", ack); end
        req = 1'b0;
        tick();
        checks++; if (txn_cnt !== 2'd1) begin failures++; $display("FAIL reset_release_cnt got=%0d exp=1", txn_cnt); end
    endtask

    task automatic test_normal();
        apply_reset();
        lat = 4'd2;
        req = 1'b1;
        tick();
        checks++; if (busy !== 1'b1 || ack !== 1'b0) begin failures++; $display("FAIL normal_accept got busy=%b ack=%b exp busy=1 ack=0", busy, ack); end
        tick();
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL normal_wait_ack got=%b exp=0", ack); end
        lat = 4'd9;
        tick();
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL normal_ack got=%b exp=1", ack); end
        tick();
        tick();
        checks++; if (ack !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL normal_hold got ack=%b err=%b exp ack=1 err=0", ack, err); end
        req = 1'b0;
        tick();
        checks++; if (ack !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL normal_release got ack=%b busy=%b exp 0 0", ack, busy); end
        checks++; if (txn_cnt !== 2'd1) begin failures++; $display("FAIL normal_cnt got=%0d exp=1", txn_cnt); end
    endtask

    task automatic test_back_to_back();
        bit seen_err;
        apply_reset();
        seen_err = 1'b0;
        lat = 4'd0;
        for (int unsigned t = 0; t < 2; t++) begin
            req = 1'b1;
            tick();
            seen_err |= err;
            checks++; if (ack !== 1'b1) begin failures++; $display("FAIL b2b_ack%0d got=%b exp=1", t, ack); end
            tick();
            seen_err |= err;
            req = 1'b0;
            tick();
            seen_err |= err;
            checks++; if (ack !== 1'b0) begin failures++; $display("FAIL b2b_drop%0d got=%b exp=0", t, ack); end
        end
        checks++; if (txn_cnt !== 2'd2) begin failures++; $display("FAIL b2b_cnt got=%0d exp=2", txn_cnt); end
        checks++; if (seen_err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", seen_err); end
    endtask

    task automatic test_violation();
        bit seen_ack;
        apply_reset();
        seen_ack = 1'b0;
        lat = 4'd5;
        req = 1'b1;
        tick();
        tick();
        seen_ack |= ack;
        req = 1'b0;
        tick();
        seen_ack |= ack;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL viol_err got=%b exp=1", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL viol_busy got=%b exp=0", busy); end
        tick();
        seen_ack |= ack;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL viol_err_pulse got=%b exp=0", err); end
        repeat (6) begin tick(); seen_ack |= ack; end
        checks++; if (seen_ack !== 1'b0) begin failures++; $display("FAIL viol_ack got=%b exp=0", seen_ack); end
        checks++; if (txn_cnt !== 2'd0) begin failures++; $display("FAIL viol_cnt got=%0d exp=0", txn_cnt); end
    endtask

    task automatic test_enable();
        bit seen_busy;
        apply_reset();
        seen_busy = 1'b0;
        enable = 1'b0;
        req    = 1'b1;
        lat    = 4'd0;
        repeat (10) begin tick(); seen_busy |= busy; end
        checks++; if (seen_busy !== 1'b0) begin failures++; $display("FAIL enable_gate busy got=%b exp=0", seen_busy); end
        enable = 1'b1;
        lat    = 4'd3;
        tick();
        enable = 1'b0;
        tick();
        tick();
        checks++; if (ack !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL enable_wait got ack=%b busy=%b exp 0 1", ack, busy); end
        tick();
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL enable_ack got=%b exp=1", ack); end
        req = 1'b0;
        tick();
        checks++; if (txn_cnt !== 2'd1) begin failures++; $display("FAIL enable_cnt got=%0d exp=1", txn_cnt); end
        enable = 1'b1;
    endtask

    task automatic test_saturation();
        apply_reset();
        lat = 4'd0;
        for (int unsigned t = 0; t < 5; t++) begin
            req = 1'b1;
            tick();
            req = 1'b0;
            tick();
        end
        checks++; if (txn_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt got=%0d exp=3", txn_cnt); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        lat = 4'd1;
        req = 1'b1;
        tick();
        tick();
        req = 1'b0;
        tick();
        req = 1'b1;
        tick();
        tick();
        checks++; if (ack !== 1'b1 || txn_cnt !== 2'd1) begin failures++; $display("FAIL areset_pre got ack=%b cnt=%0d exp ack=1 cnt=1", ack, txn_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ack !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL areset_out got ack=%b busy=%b exp 0 0", ack, busy); end
        checks++; if (txn_cnt !== 2'd0) begin failures++; $display("FAIL areset_cnt got=%0d exp=0", txn_cnt); end
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
        model_reset();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_idle got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        apply_reset();
        model_reset();
        for (int unsigned c = 0; c < 600; c++) begin
            req    = ($urandom_range(0, 9) < 7);
            enable = ($urandom_range(0, 3) != 0);
            lat    = ($urandom_range(0, 2) == 0) ? 4'd0 : TB_LAT_W'($urandom_range(0, 15));
            tick();
            checks++; if (ack !== m_ack) begin failures++; $display("FAIL rand_ack cycle=%0d got=%b exp=%b", c, ack, m_ack); end
            checks++; if (busy !== m_busy) begin failures++; $display("FAIL rand_busy cycle=%0d got=%b exp=%b", c, busy, m_busy); end
            checks++; if (err !== m_err) begin failures++; $display("FAIL rand_err cycle=%0d got=%b exp=%b", c, err, m_err); end
            checks++; if (int'(txn_cnt) !== m_cnt) begin failures++; $display("FAIL rand_cnt cycle=%0d got=%0d exp=%0d", c, txn_cnt, m_cnt); end
        end
    endtask

    initial begin
        rst    = 1'b1;
        req    = 1'b0;
        enable = 1'b1;
        lat    = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_normal();
        test_back_to_back();
        test_violation();
        test_enable();
        test_saturation();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
